// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: bus typedefs, owner codes and arbiter state shared by the arbiter slice
package mem_bus_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_I = 2'd1;
  localparam logic [1:0] OWN_D = 2'd2;
  localparam logic [2:0] IBUS_SIZE = 3'b010;
  // instruction fetches are always 32-bit reads
  function automatic cbus_req_t from_ibus(ibus_req_t r);
    return '{valid: r.valid, is_write: 1'b0, addr: r.addr, size: IBUS_SIZE, strobe: '0, data: '0};
  endfunction
  function automatic cbus_req_t from_dbus(dbus_req_t r);
    return '{valid: r.valid, is_write: |r.strobe, addr: r.addr, size: r.size, strobe: r.strobe, data: r.data};
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// mem_bus_watchdog: counts BUSY cycles without completion and aborts hung transactions
module mem_bus_watchdog #(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic done,
  output logic fire,
  output logic timeout
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  always_comb begin
    fire = (TIMEOUT_CYC != 0) && busy && !done && cnt_q == LIMIT;
    cnt_d = (busy && !done && !fire) ? cnt_q + 1'b1 : '0;
    timeout_d = timeout_q | fire;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one cbus between ibus and dbus; MEM_BUS_ARB_RR_EN selects round-robin arbitration
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       timeout,
  output logic [1:0] owner
);
  arb_state_t state_q, state_d;
  cbus_req_t lat_q, lat_d;
  logic first_q, first_d;
  logic busy, done, fire, pick_d, ok;
  logic [63:0] rdata;
  logic [31:0] iword;
`ifdef MEM_BUS_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  // last_grant: 0 = ibus, 1 = dbus; contention goes to the side not served last
  always_comb begin
    pick_d = dreq.valid & (~ireq.valid | ~last_grant_q);
    last_grant_d = (!busy && (ireq.valid || dreq.valid)) ? pick_d : last_grant_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) last_grant_q <= 1'b0;
    else last_grant_q <= last_grant_d;
  end
`else
  always_comb pick_d = dreq.valid;
`endif
  assign busy = state_q != IDLE;
  assign done = busy & cresp.ready & cresp.last;
  assign ok = done | fire;
  always_comb begin
    state_d = state_q;
    lat_d = lat_q;
    first_d = 1'b0;
    if (!busy && (ireq.valid || dreq.valid)) begin
      state_d = pick_d ? BUSY_D : BUSY_I;
      lat_d = pick_d ? from_dbus(dreq) : from_ibus(ireq);
      first_d = 1'b1;
    end else if (ok) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lat_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      first_q <= first_d;
    end
  end
  mem_bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_wdog (
    .clk(clk),
    .reset(reset),
    .busy(busy),
    .done(done),
    .fire(fire),
    .timeout(timeout)
  );
  // an aborted transaction completes with zero data so the pipeline can move on
  assign rdata = done ? cresp.data : '0;
  assign iword = lat_q.addr[2] ? rdata[63:32] : rdata[31:0];
  assign creq = busy ? lat_q : '0;
  assign iresp = state_q == BUSY_I ? ibus_resp_t'{addr_ok: first_q, data_ok: ok, data: iword} : '0;
  assign dresp = state_q == BUSY_D ? dbus_resp_t'{addr_ok: first_q, data_ok: ok, data: rdata} : '0;
  assign owner = state_q == BUSY_I ? OWN_I : state_q == BUSY_D ? OWN_D : OWN_IDLE;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table plus sequences for watchdog, reset and arbitration order
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset;
  ibus_req_t ireq;
  ibus_resp_t iresp;
  dbus_req_t dreq;
  dbus_resp_t dresp;
  cbus_req_t creq;
  cbus_resp_t cresp;
  logic timeout;
  logic [1:0] owner;
  always #5 clk = ~clk;
  mem_bus_arbiter #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .ireq(ireq),
    .iresp(iresp),
    .dreq(dreq),
    .dresp(dresp),
    .creq(creq),
    .cresp(cresp),
    .timeout(timeout),
    .owner(owner)
  );
  typedef struct packed {
    cbus_req_t  c;
    ibus_resp_t i;
    dbus_resp_t d;
    logic [1:0] own;
    logic       to;
  } out_t;
  typedef struct {
    logic       rst_n;
    ibus_req_t  i;
    dbus_req_t  d;
    cbus_resp_t c;
    out_t       exp;
  } vec_t;
  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  function automatic ibus_req_t ir(logic v, logic [63:0] a);
    return '{valid: v, addr: a};
  endfunction
  function automatic dbus_req_t dr(logic v, logic [63:0] a, logic [2:0] sz, logic [7:0] st, logic [63:0] dt);
    return '{valid: v, addr: a, size: sz, strobe: st, data: dt};
  endfunction
  function automatic cbus_resp_t cr(logic rdy, logic lst, logic [63:0] dt);
    return '{ready: rdy, last: lst, data: dt};
  endfunction
  function automatic cbus_req_t cq(logic w, logic [63:0] a, logic [2:0] sz, logic [7:0] st, logic [63:0] dt);
    return '{valid: 1'b1, is_write: w, addr: a, size: sz, strobe: st, data: dt};
  endfunction
  function automatic ibus_resp_t irs(logic aok, logic dok, logic [31:0] dt);
    return '{addr_ok: aok, data_ok: dok, data: dt};
  endfunction
  function automatic dbus_resp_t drs(logic aok, logic dok, logic [63:0] dt);
    return '{addr_ok: aok, data_ok: dok, data: dt};
  endfunction
  task automatic add(input logic rst_n, input ibus_req_t i, input dbus_req_t d, input cbus_resp_t c,
                     input cbus_req_t ec, input ibus_resp_t ei, input dbus_resp_t ed, input logic [1:0] own);
    vec_t v;
    v.rst_n = rst_n;
    v.i = i;
    v.d = d;
    v.c = c;
    v.exp = '{c: ec, i: ei, d: ed, own: own, to: 1'b0};
    vecs.push_back(v);
  endtask
  initial begin
    ibus_req_t I0;
    dbus_req_t D0, DW, DS;
    cbus_resp_t C0;
    cbus_req_t Q0, IQ, DQ, SQ;
    ibus_resp_t IR0;
    dbus_resp_t DR0;
    logic [63:0] IA, IB;
    logic [1:0] exp_own [4];
    int k;
    I0 = '0; D0 = '0; C0 = '0; Q0 = '0; IR0 = '0; DR0 = '0;
    IA = 64'h8000_0004;
    IB = 64'h8000_0008;
    IQ = cq(1'b0, IA, 3'b010, 8'h00, 64'h0);
    DW = dr(1'b1, 64'h8000_1000, 3'b011, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    DQ = cq(1'b1, 64'h8000_1000, 3'b011, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    DS = dr(1'b1, 64'h8000_2000, 3'b010, 8'h0F, 64'h1234);
    SQ = cq(1'b1, 64'h8000_2000, 3'b010, 8'h0F, 64'h1234);
    // reset and a single fetch answered three cycles after creq.valid; ireq drops and changes mid-flight
    add(1'b0, I0, D0, C0, Q0, IR0, DR0, OWN_IDLE);
    add(1'b1, I0, D0, C0, Q0, IR0, DR0, OWN_IDLE);
    add(1'b1, ir(1'b1, IA), D0, C0, Q0, IR0, DR0, OWN_IDLE);
    add(1'b1, ir(1'b1, IA), D0, C0, IQ, irs(1'b1, 1'b0, 32'h0), DR0, OWN_I);
    add(1'b1, ir(1'b0, 64'h40), D0, C0, IQ, IR0, DR0, OWN_I);
    add(1'b1, I0, D0, C0, IQ, IR0, DR0, OWN_I);
    add(1'b1, I0, D0, cr(1'b1, 1'b1, 64'h11112222_33334444), IQ, irs(1'b0, 1'b1, 32'h11112222), DR0, OWN_I);
    add(1'b1, I0, D0, C0, Q0, IR0, DR0, OWN_IDLE);
    // both request together: dbus write first, ibus after an idle cycle
    add(1'b1, ir(1'b1, IB), DW, C0, Q0, IR0, DR0, OWN_IDLE);
    add(1'b1, ir(1'b1, IB), DW, C0, DQ, IR0, drs(1'b1, 1'b0, 64'h0), OWN_D);
    add(1'b1, ir(1'b1, IB), DW, cr(1'b1, 1'b1, 64'h55556666_77778888), DQ, IR0, drs(1'b0, 1'b1, 64'h55556666_77778888), OWN_D);
    add(1'b1, ir(1'b1, IB), D0, C0, Q0, IR0, DR0, OWN_IDLE);
    add(1'b1, ir(1'b1, IB), D0, cr(1'b1, 1'b1, 64'hAAAABBBB_CCCCDDDD), cq(1'b0, IB, 3'b010, 8'h00, 64'h0), irs(1'b1, 1'b1, 32'hCCCCDDDD), DR0, OWN_I);
    add(1'b1, I0, D0, C0, Q0, IR0, DR0, OWN_IDLE);
    // reset during BUSY_D aborts without a response
    add(1'b1, I0, DS, C0, Q0, IR0, DR0, OWN_IDLE);
    add(1'b1, I0, D0, C0, SQ, IR0, drs(1'b1, 1'b0, 64'h0), OWN_D);
    add(1'b0, I0, D0, C0, SQ, IR0, DR0, OWN_D);
    add(1'b1, I0, D0, cr(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF), Q0, IR0, DR0, OWN_IDLE);
    add(1'b1, I0, D0, C0, Q0, IR0, DR0, OWN_IDLE);
    reset = 1'b0; ireq = '0; dreq = '0; cresp = '0;
    cyc();
    cyc();
    foreach (vecs[n]) begin
      reset = vecs[n].rst_n;
      ireq = vecs[n].i;
      dreq = vecs[n].d;
      cresp = vecs[n].c;
      #1;
      chk($sformatf("vec%0d", n), out_t'{c: creq, i: iresp, d: dresp, own: owner, to: timeout}, vecs[n].exp);
      cyc();
    end
    // watchdog: no response, abort lands in the ninth BUSY cycle
    dreq = dr(1'b1, 64'h8000_3000, 3'b011, 8'h00, 64'h0);
    cyc();
    dreq = '0;
    k = 1;
    #1;
    while (!dresp.data_ok && k < 20) begin
      cyc();
      k++;
      #1;
    end
    chk("timeout_cycle", k, 9);
    chk("timeout_data", dresp.data, 64'h0);
    chk("timeout_read", {creq.valid, creq.is_write}, 2'b10);
    cyc();
    #1;
    chk("timeout_sticky", {timeout, owner}, {1'b1, OWN_IDLE});
    ireq = ir(1'b1, 64'h8000_0000);
    cyc();
    ireq = '0;
    cresp = cr(1'b1, 1'b1, 64'h99998888_77776666);
    #1;
    chk("after_timeout", {iresp, timeout}, {irs(1'b1, 1'b1, 32'h77776666), 1'b1});
    cyc();
    cresp = '0;
    // reset clears the flag; completion in the would-be abort cycle wins
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    chk("timeout_cleared", timeout, 1'b0);
    dreq = dr(1'b1, 64'h8000_4000, 3'b011, 8'h00, 64'h0);
    cyc();
    dreq = '0;
    repeat (8) cyc();
    cresp = cr(1'b1, 1'b1, 64'h0BAD_F00D_0000_0001);
    #1;
    chk("race_resp", dresp, drs(1'b0, 1'b1, 64'h0BAD_F00D_0000_0001));
    cyc();
    cresp = '0;
    #1;
    chk("race_no_timeout", {timeout, owner}, {1'b0, OWN_IDLE});
    // both held valid over four transactions from a fresh reset
`ifdef MEM_BUS_ARB_RR_EN
    exp_own = '{OWN_D, OWN_I, OWN_D, OWN_I};
`else
    exp_own = '{OWN_D, OWN_D, OWN_D, OWN_D};
`endif
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    ireq = ir(1'b1, IB);
    dreq = DW;
    for (int t = 0; t < 4; t++) begin
      k = 0;
      do begin
        cyc();
        cresp = '0;
        k++;
        #1;
      end while (owner == OWN_IDLE && k < 5);
      chk($sformatf("grant%0d", t), owner, exp_own[t]);
      cresp = cr(1'b1, 1'b1, 64'h0);
    end
    cyc();
    cresp = '0;
    ireq = '0;
    dreq = '0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
